// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Optional build macro: UART_RX_PARITY_EN (adds an even-parity stage and parity_error).
package uart_rx_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    DATA      = 3'd2,
    STOP_CHK  = 3'd3,
    LOAD      = 3'd4
`ifdef UART_RX_PARITY_EN
    , PARITY_CHK = 3'd5
`endif
  } rx_state_t;

  // Visible receiver status, registered as one unit.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 ready;
    logic                 overrun;
    logic                 framing;
`ifdef UART_RX_PARITY_EN
    logic                 parity;
`endif
  } rx_status_t;

  // Returns 1 when the word holds an odd number of ones.
  function automatic logic odd_ones(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Serial line and consumer handshake of the UART receiver.
// Optional build macro: UART_RX_PARITY_EN (adds parity_error).
interface uart_rx_ctrl_if;
  import uart_rx_pkg::*;

  logic                 serial_in;
  logic                 data_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 overrun_error;
  logic                 framing_error;
`ifdef UART_RX_PARITY_EN
  logic                 parity_error;
`endif

  modport slave (
    input  serial_in, data_read,
    output rx_data, data_ready, overrun_error, framing_error
`ifdef UART_RX_PARITY_EN
    , output parity_error
`endif
  );

  modport master (
    output serial_in, data_read,
    input  rx_data, data_ready, overrun_error, framing_error
`ifdef UART_RX_PARITY_EN
    , input parity_error
`endif
  );

endinterface

// File: rtl/uart_rx_ctrl_counter.sv
// flex_counter: modulo-rollover_val cycle counter; rollover_flag marks the last count
// of each period and serves as the bit-period sample strobe.
module flex_counter #(
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count;

  // Flag is combinational so the strobe lands exactly rollover_val cycles after a clear.
  assign rollover_flag = count_enable && (count == rollover_val - NUM_CNT_BITS'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            count <= '0;
    else if (clear)        count <= '0;
    else if (count_enable) count <= rollover_flag ? '0 : count + NUM_CNT_BITS'(1);
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 8N1 frame capture with ready/overrun/framing status.
// Optional build macro: UART_RX_PARITY_EN (even-parity bit before the stop bit).
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic           clk,
  input  logic           n_rst,
  uart_rx_ctrl_if.slave  bus
);

  localparam logic [7:0] FULL_PER = 8'(CLKS_PER_BIT);
  localparam logic [7:0] HALF_PER = 8'(CLKS_PER_BIT / 2);

  logic                 sync1, sin, sin_d;
  rx_state_t            state, state_n;
  logic                 cnt_clear, cnt_en, strobe;
  logic [7:0]           roll_val;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  rx_status_t           stat;

  // sin_d keeps the previous synchronized level for start-edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      sin   <= 1'b1;
      sin_d <= 1'b1;
    end else begin
      sync1 <= bus.serial_in;
      sin   <= sync1;
      sin_d <= sin;
    end
  end

  flex_counter #(.NUM_CNT_BITS(8)) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (roll_val),
    .rollover_flag(strobe)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_en   = 1'b0;
    roll_val = FULL_PER;
    case (state)
      IDLE:      if (sin_d && !sin) state_n = START_CHK;
      START_CHK: begin
        cnt_en   = 1'b1;
        roll_val = HALF_PER;
        if (strobe) state_n = sin ? IDLE : DATA;
      end
      DATA: begin
        cnt_en = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (strobe && bit_cnt == 3'd7) state_n = PARITY_CHK;
`else
        if (strobe && bit_cnt == 3'd7) state_n = STOP_CHK;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY_CHK: begin
        cnt_en = 1'b1;
        if (strobe) state_n = STOP_CHK;
      end
`endif
      STOP_CHK: begin
        cnt_en = 1'b1;
        if (strobe) state_n = sin ? LOAD : IDLE;
      end
      LOAD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Every state entry restarts the bit-period timer.
    cnt_clear = (state_n != state);
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                            par_bad <= 1'b0;
    else if (state == PARITY_CHK && strobe) par_bad <= odd_ones(shift_reg) ^ sin;
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      stat      <= '0;
    end else begin
      if (state == DATA && strobe) begin
        shift_reg <= {sin, shift_reg[DATA_BITS-1:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end else if (state != DATA && state_n == DATA) begin
        bit_cnt   <= '0;
      end

      if (state == START_CHK && strobe && !sin) stat.framing <= 1'b0;
      if (state == STOP_CHK  && strobe && !sin) stat.framing <= 1'b1;

      // A read coinciding with the load is absorbed by the new byte.
      if (state == LOAD) begin
        stat.data    <= shift_reg;
        stat.ready   <= 1'b1;
        stat.overrun <= bus.data_read ? 1'b0 : (stat.overrun | stat.ready);
`ifdef UART_RX_PARITY_EN
        stat.parity  <= par_bad;
`endif
      end else if (bus.data_read) begin
        stat.ready   <= 1'b0;
        stat.overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
        stat.parity  <= 1'b0;
`endif
      end
    end
  end

  assign bus.rx_data       = stat.data;
  assign bus.data_ready    = stat.ready;
  assign bus.overrun_error = stat.overrun;
  assign bus.framing_error = stat.framing;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error  = stat.parity;
`endif

endmodule
